// File: rtl/aq_djpeg_pkg.sv
// Shared types and constants for the IDCT transpose-buffer read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aq_djpeg_pkg;

    // Read sequencer FSM encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rdseq_state_e;

    // Last word address of a 32-word bank
    localparam logic [4:0] BLK_LAST = 5'd31;

    // Default width of one half of an element pair
    localparam int W_DEF = 16;

    // 16-bit saturating increment used by the statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aq_djpeg_rdseq_fifo.sv
// Small synchronous FIFO holding {idx, a, b} element pairs ahead of the second IDCT pass.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: push and pop together while full is accepted; a lone push while full is dropped.
module aq_djpeg_rdseq_fifo #(
    parameter int  DW    = 37,
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next-state for storage, pointers and occupancy; clr wins over traffic
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: rtl/aq_djpeg_idctb_rdseq.sv
// Read-side sequencer of the IDCT transpose buffer: walks a readable bank's 32 addresses, undoes the A/B swap, streams pairs.
// Latency: first pair valid 2 cycles after buf_enable rises; one pair per cycle thereafter with out_ready high.
// Backpressure: reads are issued only with FIFO credit; out_* hold while out_valid & !out_ready. Stats via AQ_DJPEG_RDSEQ_STAT_EN.
module aq_djpeg_idctb_rdseq
    import aq_djpeg_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         buf_enable,
    output logic         buf_read,
    output logic [4:0]   buf_addr,
    input  logic [W-1:0] buf_a,
    input  logic [W-1:0] buf_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [4:0]   out_idx,
    output logic         out_first,
    output logic         out_last,
    output logic         busy,
    output logic [15:0]  stat_blocks,
    output logic [15:0]  stat_stalls
);

    localparam int FW = 5 + 2 * W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    typedef logic [SW-1:0] sum_t;

    rdseq_state_e  state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic          inflight_q, inflight_d;
    logic          arm_q, arm_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] push_dat, head_dat;
    logic          push, pop, credit, need, issue;
    logic          swap_mis;
    logic [W-1:0]  raw_a, raw_b, cap_a, cap_b;
    logic [4:0]    head_idx;

    // A pair popped this cycle frees its slot for a read issued this cycle
    assign pop    = out_valid & out_ready;
    assign credit = (sum_t'(fifo_count) + sum_t'(inflight_q)) < (sum_t'(FIFO_DEPTH) + sum_t'(pop));
    // A new block starts only at address 0 with the bank readable; mid-block reads ignore buf_enable
    assign need   = (cnt_q != '0) | buf_enable;
    // arm_q keeps the read port quiet during and just after reset/init
    assign issue  = arm_q & ~init & credit & need;

    assign buf_read = issue;
    assign buf_addr = cnt_q;

    // FSM, address counter and read-pipeline tracking
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        inflight_d = issue;
        arm_d      = 1'b1;
        if (init) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            idx_d      = '0;
            inflight_d = 1'b0;
            arm_d      = 1'b0;
        end else if (issue) begin
            state_d = ST_RUN;
            cnt_d   = cnt_q + 5'd1;
            idx_d   = cnt_q;
        end else if ((cnt_q == '0) && !buf_enable) begin
            state_d = ST_IDLE;
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            arm_q      <= arm_d;
        end
    end

    // The buffer muxes its registered word with the current address bit 4, which may already
    // belong to the next read; first re-align to the issued address, then undo that address's swap.
    always_comb begin
        swap_mis = cnt_q[4] ^ idx_q[4];
        raw_a    = swap_mis ? buf_b : buf_a;
        raw_b    = swap_mis ? buf_a : buf_b;
        cap_a    = idx_q[4] ? raw_b : raw_a;
        cap_b    = idx_q[4] ? raw_a : raw_b;
    end

    assign push     = inflight_q;
    assign push_dat = {idx_q, cap_a, cap_b};

    aq_djpeg_rdseq_fifo #(
        .DW    (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (init),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_idx  = head_dat[FW-1 -: 5];
    assign out_valid = ~fifo_empty;
    assign out_a     = head_dat[2*W-1 -: W];
    assign out_b     = head_dat[W-1:0];
    assign out_idx   = head_idx;
    assign out_first = out_valid & (head_idx == 5'd0);
    assign out_last  = out_valid & (head_idx == BLK_LAST);
    assign busy      = (state_q != ST_IDLE) | inflight_q | ~fifo_empty;

`ifdef AQ_DJPEG_RDSEQ_STAT_EN
    logic [15:0] stat_blocks_q, stat_blocks_d;
    logic [15:0] stat_stalls_q, stat_stalls_d;

    // Saturating counters of completed blocks and credit-starved RUN cycles
    always_comb begin
        stat_blocks_d = stat_blocks_q;
        stat_stalls_d = stat_stalls_q;
        if (init) begin
            stat_blocks_d = '0;
            stat_stalls_d = '0;
        end else begin
            if (pop && out_last) begin
                stat_blocks_d = sat_inc16(stat_blocks_q);
            end
            if ((state_q == ST_RUN) && !credit) begin
                stat_stalls_d = sat_inc16(stat_stalls_q);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_blocks_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_blocks_q <= stat_blocks_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_blocks = stat_blocks_q;
    assign stat_stalls = stat_stalls_q;
`else
    assign stat_blocks = '0;
    assign stat_stalls = '0;
`endif

    // Credit accounting must make a push into a full FIFO impossible
    a_push_not_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_aq_djpeg_idctb_rdseq.sv
// Bench for the transpose-buffer read sequencer: buffer model, pair scoreboard, directed and random traffic.
// Latency: n/a.
// Backpressure: out_ready driven fixed, 1-0-0-1 pattern or random.
module tb_aq_djpeg_idctb_rdseq;

    localparam int W     = 16;
    localparam int DEPTH = 2;
`ifdef AQ_DJPEG_RDSEQ_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init = 1'b0;
    logic         buf_enable = 1'b0;
    logic         out_ready = 1'b0;
    logic         buf_read;
    logic [4:0]   buf_addr;
    logic [W-1:0] buf_a, buf_b;
    logic         out_valid;
    logic [W-1:0] out_a, out_b;
    logic [4:0]   out_idx;
    logic         out_first, out_last, busy;
    logic [15:0]  stat_blocks, stat_stalls;

    always #5 clk = ~clk;

    aq_djpeg_idctb_rdseq dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .buf_enable  (buf_enable),
        .buf_read    (buf_read),
        .buf_addr    (buf_addr),
        .buf_a       (buf_a),
        .buf_b       (buf_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_idx     (out_idx),
        .out_first   (out_first),
        .out_last    (out_last),
        .busy        (busy),
        .stat_blocks (stat_blocks),
        .stat_stalls (stat_stalls)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- buffer model: memory A/B per bank, registered read, swap by current addr[4]
    logic [W-1:0] blk_a [16][32];
    logic [W-1:0] blk_b [16][32];
    logic [W-1:0] mem_ra = '0;
    logic [W-1:0] mem_rb = '0;
    int rd_blk  = 0;
    int starts  = 0;
    int issued  = 0;
    int popped  = 0;

    assign buf_a = buf_addr[4] ? mem_rb : mem_ra;
    assign buf_b = buf_addr[4] ? mem_ra : mem_rb;

    always @(posedge clk) begin
        if (buf_read) begin
            mem_ra <= blk_a[rd_blk % 16][buf_addr];
            mem_rb <= blk_b[rd_blk % 16][buf_addr];
            if (buf_addr == 5'd31) rd_blk <= rd_blk + 1;
            if (buf_addr == 5'd0)  starts <= starts + 1;
        end
        if (!rst || init) begin
            issued <= 0;
            popped <= 0;
        end else begin
            if (buf_read) issued <= issued + 1;
            if (out_valid && out_ready) popped <= popped + 1;
        end
    end

    // ---------------- expected pair stream
    logic [4:0]   e_idx [1024];
    logic [W-1:0] e_a   [1024];
    logic [W-1:0] e_b   [1024];
    int exp_wr = 0;
    int exp_rd = 0;
    int exp_blocks = 0;
    int cont_from = 0;
    bit cont_chk = 1'b0;
    int outst;

    task automatic fill_blk(input int k, input bit pat);
        for (int i = 0; i < 32; i++) begin
            blk_a[k % 16][i] = pat ? W'(i) : W'($urandom);
            blk_b[k % 16][i] = pat ? W'(16'h100 + i) : W'($urandom);
        end
    endtask

    task automatic push_blk(input int k);
        for (int i = 0; i < 32; i++) begin
            e_idx[exp_wr] = 5'(i);
            e_a[exp_wr]   = blk_a[k % 16][i];
            e_b[exp_wr]   = blk_b[k % 16][i];
            exp_wr++;
        end
    endtask

    // Scoreboard: each accepted pair against the stream, plus credit and gap rules
    always @(negedge clk) begin
        if (!rst || init) begin
            exp_rd     <= exp_wr;
            exp_blocks <= 0;
        end else begin
            outst = issued - popped - ((out_valid && out_ready) ? 1 : 0);
            if (outst >= DEPTH) check_eq("no_credit_read", buf_read, 0);
            if (cont_chk && exp_rd > cont_from && exp_rd < exp_wr) check_eq("stream_gap", out_valid, 1);
            if (out_valid && out_ready) begin
                if (exp_rd >= exp_wr) begin
                    check_eq("extra_pair", out_valid, 0);
                end else begin
                    check_eq("pair_idx", out_idx, e_idx[exp_rd]);
                    check_eq("pair_a", out_a, e_a[exp_rd]);
                    check_eq("pair_b", out_b, e_b[exp_rd]);
                    check_eq("pair_first", out_first, e_idx[exp_rd] == 5'd0);
                    check_eq("pair_last", out_last, e_idx[exp_rd] == 5'd31);
                    if (e_idx[exp_rd] == 5'd31) exp_blocks <= exp_blocks + 1;
                    exp_rd <= exp_rd + 1;
                end
            end
        end
    end

    // ---------------- drivers
    int rdy_mode  = 0;
    int en_target = 0;
    int rdy_ph    = 0;
    logic [3:0] rdy_pat = 4'b1001;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = rdy_pat[rdy_ph]; rdy_ph = (rdy_ph + 1) % 4; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            buf_enable = (starts < en_target);
        end
    end

    task automatic wait_drain(input string tag, input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(posedge clk);
            #1;
            if (exp_rd == exp_wr && !busy) done = 1'b1;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic wait_pops(input string tag, input int n, input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(posedge clk);
            #1;
            if (exp_rd >= n) done = 1'b1;
        end
        check_eq(tag, done, 1);
    endtask

    task automatic pulse_init();
        @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence
    initial begin
        int base;
        #1 rst = 1'b0;
        #2;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_read", buf_read, 0);
        check_eq("rst_addr", buf_addr, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_first", out_first, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_a", out_a, 0);
        check_eq("rst_idx", out_idx, 0);
        check_eq("rst_sblk", stat_blocks, 0);
        check_eq("rst_sstl", stat_stalls, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // 1: single patterned block, full rate, 2-cycle latency
        fill_blk(rd_blk, 1'b1);
        cont_from = exp_wr;
        push_blk(rd_blk);
        cont_chk = 1'b1;
        @(posedge clk);
        #1 en_target = starts + 1;
        @(negedge clk) check_eq("lat_c0", out_valid, 0);
        @(negedge clk) check_eq("lat_c1", out_valid, 0);
        @(negedge clk) check_eq("lat_c2", out_valid, 1);
        check_eq("lat_idx0", out_idx, 0);
        wait_drain("drain_t1", 200);
        cont_chk = 1'b0;

        // 3: backpressure 1,0,0,1
        fill_blk(rd_blk, 1'b0);
        push_blk(rd_blk);
        rdy_mode = 1;
        @(posedge clk);
        #1 en_target = starts + 1;
        wait_drain("drain_t3", 400);
        check_eq("stalls_seen", stat_stalls != 16'd0, STAT_EN);
        rdy_mode = 0;

        // 4: three back-to-back blocks, no gaps
        pulse_init();
        for (int k = 0; k < 3; k++) fill_blk(rd_blk + k, 1'b0);
        cont_from = exp_wr;
        for (int k = 0; k < 3; k++) push_blk(rd_blk + k);
        cont_chk = 1'b1;
        @(posedge clk);
        #1 en_target = starts + 3;
        wait_drain("drain_t4", 600);
        cont_chk = 1'b0;
        check_eq("stat_blocks3", stat_blocks, STAT_EN ? exp_blocks : 0);

        // 5: init mid-block with the FIFO full
        fill_blk(rd_blk, 1'b0);
        base = exp_wr;
        push_blk(rd_blk);
        @(posedge clk);
        #1 en_target = starts + 1;
        wait_pops("reach_idx8", base + 8, 100);
        rdy_mode = 3;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("pre_init_valid", out_valid, 1);
        check_eq("pre_init_read", buf_read, 0);
        pulse_init();
        @(negedge clk);
        check_eq("init_valid", out_valid, 0);
        check_eq("init_read", buf_read, 0);
        check_eq("init_addr", buf_addr, 0);
        check_eq("init_busy", busy, 0);
        check_eq("init_sblk", stat_blocks, 0);
        check_eq("init_sstl", stat_stalls, 0);
        rdy_mode = 0;
        fill_blk(rd_blk, 1'b0);
        push_blk(rd_blk);
        @(posedge clk);
        #1 en_target = starts + 1;
        wait_drain("drain_t5", 200);

        // 6: asynchronous reset mid-RUN with buf_enable high
        fill_blk(rd_blk, 1'b0);
        base = exp_wr;
        push_blk(rd_blk);
        @(posedge clk);
        #1 en_target = starts + 1;
        wait_pops("reach_idx10", base + 10, 100);
        en_target = starts + 100;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_read", buf_read, 0);
        check_eq("arst_addr", buf_addr, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_a", out_a, 0);
        check_eq("arst_b", out_b, 0);
        check_eq("arst_idx", out_idx, 0);
        check_eq("arst_sblk", stat_blocks, 0);
        en_target = starts;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("idle_read", buf_read, 0);
            check_eq("idle_busy", busy, 0);
        end

        // 7: random backpressure over several blocks
        for (int k = 0; k < 3; k++) fill_blk(rd_blk + k, 1'b0);
        for (int k = 0; k < 3; k++) push_blk(rd_blk + k);
        rdy_mode = 2;
        @(posedge clk);
        #1 en_target = starts + 3;
        wait_drain("drain_t7", 1500);
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
